// File: rtl/jt12_lfo_pm.sv
// jt12_lfo_pm
//  LFO counter and vibrato (phase modulation) stage that sits just before the
//  phase generator. A 7-bit LFO counter advances once every P rounds of 24
//  slots (P selected by lfo_freq). Each slot's F-number is offset by an amount
//  derived from the LFO position, the slot's PM sensitivity and the upper
//  F-number bits; block is passed through with matching delay.
//
// Ports
//  clk       system clock
//  rst       synchronous reset, active-high (wins over clk_en)
//  clk_en    clock enable; all state advances only when high
//  zero      one enabled cycle per 24-slot round
//  lfo_en    LFO enable; when low the LFO is held cleared
//  lfo_freq  LFO rate select
//  pms       PM sensitivity of the current slot's channel
//  fnum_in   current slot's F-number
//  block_in  current slot's block
//  fnum_I    modulated F-number, 2 enabled cycles after fnum_in
//  block_I   block, 2 enabled cycles after block_in
//  lfo_mod   current LFO counter value (AM source)

module jt12_lfo_pm #(
    parameter int PM_SHIFT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        zero,
    input  logic        lfo_en,
    input  logic [2:0]  lfo_freq,
    input  logic [2:0]  pms,
    input  logic [10:0] fnum_in,
    input  logic [2:0]  block_in,
    output logic [10:0] fnum_I,
    output logic [2:0]  block_I,
    output logic [6:0]  lfo_mod
);

    logic [6:0]  lfo_cnt;
    logic [6:0]  div;
    logic [6:0]  per_m1;

    logic [4:0]  step;
    logic [2:0]  idx;
    logic [4:0]  gain;
    logic [7:0]  depth;
    logic [14:0] prod_a;

    logic [14:0] prod_q;
    logic        sgn_q;
    logic [10:0] fnum_q;
    logic [2:0]  block_q;

    logic [14:0] off_w;
    logic [14:0] sum_w;
    logic [10:0] diff_w;
    logic [10:0] fnum_b;

    // Divider terminal count (period minus one, in rounds)
    always_comb begin
        per_m1 = 7'd107;
        case (lfo_freq)
            3'd0: per_m1 = 7'd107;
            3'd1: per_m1 = 7'd76;
            3'd2: per_m1 = 7'd70;
            3'd3: per_m1 = 7'd66;
            3'd4: per_m1 = 7'd61;
            3'd5: per_m1 = 7'd43;
            3'd6: per_m1 = 7'd7;
            3'd7: per_m1 = 7'd4;
            default: per_m1 = 7'd107;
        endcase
    end

    // Triangle position: upper half of each 16-step half-period mirrors back down
    always_comb begin
        step = lfo_cnt[6:2];
        idx  = step[3] ? ~step[2:0] : step[2:0];
        gain = 5'd0;
        case (pms)
            3'd0: gain = 5'd0;
            3'd1: gain = 5'd1;
            3'd2: gain = 5'd2;
            3'd3: gain = 5'd3;
            3'd4: gain = 5'd4;
            3'd5: gain = 5'd6;
            3'd6: gain = 5'd12;
            3'd7: gain = 5'd24;
            default: gain = 5'd0;
        endcase
        depth  = 8'(idx) * 8'(gain);
        prod_a = 15'(fnum_in[10:4]) * 15'(depth);
    end

    // Offset never exceeds 83, so the upward sum can only overflow 11 bits
    // by a small amount (saturate) and the downward path cannot underflow.
    always_comb begin
        off_w  = prod_q >> PM_SHIFT;
        sum_w  = {4'd0, fnum_q} + off_w;
        diff_w = fnum_q - off_w[10:0];
        if (sgn_q)
            fnum_b = diff_w;
        else if (sum_w > 15'd2047)
            fnum_b = 11'h7FF;
        else
            fnum_b = sum_w[10:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfo_cnt <= 7'd0;
            div     <= 7'd0;
            prod_q  <= 15'd0;
            sgn_q   <= 1'b0;
            fnum_q  <= 11'd0;
            block_q <= 3'd0;
            fnum_I  <= 11'd0;
            block_I <= 3'd0;
        end else if (clk_en) begin
            if (zero) begin
                if (!lfo_en) begin
                    div     <= 7'd0;
                    lfo_cnt <= 7'd0;
                end else if (div >= per_m1) begin
                    // >= so a lowered rate mid-count wraps on the next round
                    div     <= 7'd0;
                    lfo_cnt <= lfo_cnt + 7'd1;
                end else begin
                    div <= div + 7'd1;
                end
            end
            prod_q  <= prod_a;
            sgn_q   <= step[4];
            fnum_q  <= fnum_in;
            block_q <= block_in;
            fnum_I  <= fnum_b;
            block_I <= block_q;
        end
    end

    assign lfo_mod = lfo_cnt;

endmodule

// File: tb/tb_jt12_lfo_pm.sv
module tb_jt12_lfo_pm;

    logic        clk = 1'b0;
    logic        rst, clk_en, zero, lfo_en;
    logic [2:0]  lfo_freq, pms, block_in;
    logic [10:0] fnum_in;
    logic [10:0] fnum_I;
    logic [2:0]  block_I;
    logic [6:0]  lfo_mod;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_cnt, m_div;
    int m_out_f, m_out_b, m_pend_f, m_pend_b;
    int periods[8] = '{108, 77, 71, 67, 62, 44, 8, 5};
    int gains[8]   = '{0, 1, 2, 3, 4, 6, 12, 24};

    jt12_lfo_pm #(.PM_SHIFT(8)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .zero(zero),
        .lfo_en(lfo_en), .lfo_freq(lfo_freq), .pms(pms),
        .fnum_in(fnum_in), .block_in(block_in),
        .fnum_I(fnum_I), .block_I(block_I), .lfo_mod(lfo_mod)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Vibrato as a triangle wave: 32 LFO steps per period, first half raises
    // pitch, second half lowers it; magnitude rises 0..7 then falls 7..0.
    function automatic int ref_pm(input int cnt, input int p, input int f);
        int s, pos, mag, off, r;
        s   = cnt / 4;
        pos = s % 16;
        mag = (pos < 8) ? pos : 15 - pos;
        off = ((f / 16) * mag * gains[p]) / 256;
        if (s >= 16) r = f - off;
        else         r = (f + off > 2047) ? 2047 : f + off;
        return r;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_cnt = 0; m_div = 0;
            m_out_f = 0; m_out_b = 0; m_pend_f = 0; m_pend_b = 0;
        end else if (clk_en) begin
            m_out_f  = m_pend_f;
            m_out_b  = m_pend_b;
            m_pend_f = ref_pm(m_cnt, int'(pms), int'(fnum_in));
            m_pend_b = int'(block_in);
            if (zero) begin
                if (!lfo_en) begin
                    m_cnt = 0; m_div = 0;
                end else if (m_div + 1 >= periods[lfo_freq]) begin
                    m_div = 0; m_cnt = (m_cnt + 1) % 128;
                end else begin
                    m_div++;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("fnum_I",  int'(fnum_I),  m_out_f);
        chk("block_I", int'(block_I), m_out_b);
        chk("lfo_mod", int'(lfo_mod), m_cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1; clk_en = 1'b0; zero = 1'b0;
        cyc();
        chk("rst_fnum", int'(fnum_I), 0);
        chk("rst_lfo",  int'(lfo_mod), 0);
        rst = 1'b0; clk_en = 1'b1;
    endtask

    task automatic rand_slot();
        pms      = 3'($urandom_range(0, 7));
        fnum_in  = 11'($urandom);
        block_in = 3'($urandom);
    endtask

    task automatic run_zeros(input int n);
        for (int i = 0; i < n; i++) begin
            rand_slot();
            zero = 1'b1;
            cyc();
        end
        zero = 1'b0;
    endtask

    // Drive one slot, then one filler; its result is on fnum_I after that.
    task automatic pm_probe(input string tag, input int f, input int p, input int exp);
        zero = 1'b0; fnum_in = 11'(f); pms = 3'(p); block_in = 3'd2;
        cyc();
        rand_slot();
        cyc();
        chk(tag, int'(fnum_I), exp);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; zero = 1'b0; lfo_en = 1'b0; lfo_freq = 3'd0;
        pms = 3'd0; fnum_in = 11'd0; block_in = 3'd0;

        // Reset and LFO disabled: pass-through
        do_reset();
        lfo_en = 1'b0; pms = 3'd7; fnum_in = 11'h123; block_in = 3'd5;
        cyc(); cyc();
        chk("bypass_fnum",  int'(fnum_I),  'h123);
        chk("bypass_block", int'(block_I), 5);
        chk("bypass_lfo",   int'(lfo_mod), 0);

        // Fastest rate: 5 rounds per step, wrap after 640 rounds
        lfo_en = 1'b1; lfo_freq = 3'd7;
        run_zeros(5);
        chk("lfo_first_step", int'(lfo_mod), 1);
        run_zeros(635);
        chk("lfo_wrap", int'(lfo_mod), 0);

        // Vibrato points: cnt 0x1C, 0x20, 0x5C
        run_zeros(28 * 5);
        chk("cnt_1c", int'(lfo_mod), 'h1C);
        pm_probe("pm_up",  'h400, 7, 'h42A);
        pm_probe("pm_sat", 'h7FF, 7, 'h7FF);
        pm_probe("pm_pms0", 'h400, 0, 'h400);
        run_zeros(4 * 5);
        chk("cnt_20", int'(lfo_mod), 'h20);
        pm_probe("pm_mirror", 'h400, 7, 'h42A);
        run_zeros(60 * 5);
        chk("cnt_5c", int'(lfo_mod), 'h5C);
        pm_probe("pm_down", 'h400, 7, 'h3D6);

        // Rate lowered mid-count wraps on next round
        do_reset();
        lfo_en = 1'b1; lfo_freq = 3'd0;
        run_zeros(70);
        chk("div70_cnt", int'(lfo_mod), 0);
        lfo_freq = 3'd6;
        run_zeros(1);
        chk("rate_switch", int'(lfo_mod), 1);
        lfo_en = 1'b0;
        run_zeros(1);
        chk("lfo_disable", int'(lfo_mod), 0);

        // Slot stream with clock-enable gaps
        lfo_en = 1'b1; lfo_freq = 3'd7;
        for (int s = 0; s < 24; s++) begin
            clk_en = 1'b1;
            zero = (s == 0);
            pms = 3'(s % 8); fnum_in = 11'(s * 85 + 7); block_in = 3'(s);
            cyc();
            if (s == 10) begin
                clk_en = 1'b0;
                rand_slot();
                zero = 1'b1;
                for (int k = 0; k < 3; k++) cyc();
                chk("hold_lfo", int'(lfo_mod), m_cnt);
            end
        end
        clk_en = 1'b1; zero = 1'b0;
        cyc(); cyc();

        // Randomized stress against the model
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            clk_en = ($urandom_range(0, 9) < 8);
            zero   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) lfo_freq = 3'($urandom);
            if ($urandom_range(0, 199) == 0) lfo_en = ~lfo_en;
            if (i % 500 == 0) lfo_freq = 3'($urandom_range(6, 7));
            rand_slot();
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
